// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if: payload handshake and serial output bundle for seq_frame_tx
interface seq_frame_tx_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              out;
    logic              frame_start;
    logic              busy;
    modport master (output in_data, in_valid, input in_ready, out, frame_start, busy);
    modport slave  (input in_data, in_valid, output in_ready, out, frame_start, busy);
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial framer emitting sync 1001, MSB-first payload and a zero gap; PARITY_EN adds an even-parity bit
module seq_frame_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic             clk,
    input  logic             reset,
    seq_frame_tx_if.slave    bus
);
    localparam int BW = $clog2(DATA_W + 1);
`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP_ST} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP_ST} state_t;
`endif
    state_t            state, state_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [3:0]        sub_cnt, sub_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic              out_nxt;
`ifdef PARITY_EN
    logic              par, par_nxt;
`endif

    assign bus.in_ready = state == IDLE;

    // next-state, counters and the bit that will be on the line next cycle
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        sub_nxt   = sub_cnt;
        sh_nxt    = sh;
`ifdef PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: if (bus.in_valid) begin
                state_nxt = SYNC;
                sub_nxt   = 4'd0;
                sh_nxt    = bus.in_data;
`ifdef PARITY_EN
                par_nxt   = ^bus.in_data;
`endif
            end
            SYNC: if (sub_cnt == 4'd3) begin
                state_nxt = DATA;
                bit_nxt   = '0;
            end else begin
                sub_nxt = sub_cnt + 4'd1;
            end
            DATA: if (bit_cnt == BW'(DATA_W - 1)) begin
`ifdef PARITY_EN
                state_nxt = PAR;
`else
                state_nxt = GAP > 0 ? GAP_ST : IDLE;
`endif
                sub_nxt = 4'd0;
            end else begin
                bit_nxt = bit_cnt + BW'(1);
                sh_nxt  = sh << 1;
            end
`ifdef PARITY_EN
            PAR: begin
                state_nxt = GAP > 0 ? GAP_ST : IDLE;
                sub_nxt   = 4'd0;
            end
`endif
            GAP_ST: if (sub_cnt == 4'(GAP - 1)) state_nxt = IDLE;
                    else sub_nxt = sub_cnt + 4'd1;
            default: state_nxt = IDLE;
        endcase
        out_nxt = state_nxt == SYNC ? (sub_nxt == 4'd0 || sub_nxt == 4'd3) :
                  state_nxt == DATA ? sh_nxt[DATA_W-1] : 1'b0;
`ifdef PARITY_EN
        if (state_nxt == PAR) out_nxt = par_nxt;
`endif
    end

    // state and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            sub_cnt         <= '0;
            sh              <= '0;
            bus.out         <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
`ifdef PARITY_EN
            par             <= 1'b0;
`endif
        end else begin
            state           <= state_nxt;
            bit_cnt         <= bit_nxt;
            sub_cnt         <= sub_nxt;
            sh              <= sh_nxt;
            bus.out         <= out_nxt;
            bus.frame_start <= state == IDLE && state_nxt == SYNC;
            bus.busy        <= state_nxt != IDLE;
`ifdef PARITY_EN
            par             <= par_nxt;
`endif
        end
    end
endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
Serial frame transmitter that produces the bit stream a 1001 sequence detector consumes. It accepts a parallel payload word over a valid/ready handshake. It then emits, one bit per clock on a single serial line: the sync pattern 1001, the payload MSB-first, and a fixed idle gap of zeros. It sits at the transmit end of the serial sync link and serves as the stimulus source for detector blocks.

Parameters:
DATA_W, 8, payload width in bits (legal range 1..32)
GAP, 2, idle zero bits driven after each frame before the next frame may start (legal range 0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
in_data  input  DATA_W  payload word, sampled when in_valid && in_ready
in_valid  input  1  payload available
in_ready  output  1  high only in IDLE
out  output  1  serial bit, registered
frame_start  output  1  one-cycle pulse, high in the cycle the first sync bit is on out
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). No asynchronous paths.
- Reset values: state=IDLE, out=0, frame_start=0, busy=0, in_ready=1 once reset deasserts. The shift register and counters are cleared.
- All outputs are registered, except in_ready, which is decoded from state.
- States: IDLE, SYNC, DATA, PAR (present only with PARITY_EN), GAP.
- IDLE:
  - out=0.
  - If in_valid: capture in_data into the shift register and go to SYNC.
  - Accept cycle N: out=1 and frame_start=1 at cycle N+1.
- SYNC: drives 1,0,0,1 on four consecutive cycles (N+1..N+4), then goes to DATA.
- DATA:
  - Drives the payload MSB-first, one bit per cycle, for DATA_W cycles.
  - Bit counter width is clog2(DATA_W+1). The counter does not wrap mid-frame.
  - Then goes to PAR if enabled, else GAP.
- GAP:
  - out=0 for GAP cycles, then returns to IDLE.
  - If GAP=0, DATA/PAR goes directly to IDLE.
- Frame length excluding the IDLE cycle: 4+DATA_W(+1)+GAP cycles.
- Back-to-back: in_valid held high continuously gives one accept per frame. The next frame's first sync bit follows immediately after the last gap bit plus one IDLE cycle.
- in_data changes while busy are ignored. The payload is frozen at accept.
- in_valid asserted during reset: not accepted. The first accept is possible in the first cycle with reset low.
- Reset mid-frame: on the next edge out=0 and state=IDLE. The frame is abandoned; no partial sync or data continues.
- The payload is not scrambled or stuffed. Payloads containing 1001, or overlapping with sync/gap bits, can produce extra detections downstream. Callers own payload choice.

Optional Feature:
Macro PARITY_EN.
- Defined: PAR state is compiled in. After the last data bit, one cycle drives the even-parity bit (XOR of all DATA_W payload bits), then GAP. Frame length grows by 1.
- Undefined: no PAR state and no parity logic. DATA goes straight to GAP.

Test Plan:
- Reset, then accept in_data=8'hA5 at cycle 10 (GAP=2) -> out from cycle 11: 1,0,0,1,1,0,1,0,0,1,0,1,0,0. frame_start high only at cycle 11. busy high cycles 11-24. in_ready high again at cycle 25.
- in_valid held high with payloads 8'h00 then 8'hFF -> second frame_start exactly 15 cycles after the first. Second payload captured only at its accept cycle. Value changes while busy are ignored.
- Loopback: out into a 1001 overlapping Mealy detector, payload 8'h00, GAP=2 -> exactly one detector pulse per frame, on the cycle the fourth sync bit (1) is on out.
- Assert reset during DATA bit 3 of a frame -> out=0 and busy=0 on the next edge, in_ready=1 after reset drops, no further sync or data bits. A new accept starts a clean frame.
- PARITY_EN defined, payload 8'h07 -> a parity bit of 1 follows the data LSB. Payload 8'h03 -> parity bit 0. Frame length 15 cycles excluding IDLE with GAP=2.
- DATA_W=1, GAP=0, payload 1'b1 -> out 1,0,0,1,1, then IDLE. The next accept is possible on the following cycle.
